// File: rtl/reg_pipe_if.sv
// -----------------------------------------------------------------------------
// reg_pipe_if
// Bundle of every reg_pipe signal apart from clock and reset.
//   CE        : clock enable for shift, refill counter and depth sampling
//   SCLR      : synchronous clear, active-high
//   DEPTH     : requested depth, 0..MAX_DEPTH (larger values are clamped)
//   IN_VALID  : input word valid
//   IN_DATA   : input word
//   OUT_VALID : output word valid
//   OUT_DATA  : output word
//   FILLING   : refill in progress after a depth change
//   DEPTH_ERR : sticky out-of-range depth flag
//   OUT_CNT   : saturating valid-output count (only with REG_PIPE_STATS_EN)
// Modports: master drives the inputs (producer/bench), slave is the pipe.
// -----------------------------------------------------------------------------
interface reg_pipe_if #(
  parameter int WIDTH     = 18,
  parameter int MAX_DEPTH = 4
);
  localparam int DW = $clog2(MAX_DEPTH + 1);

  logic             CE;
  logic             SCLR;
  logic [DW-1:0]    DEPTH;
  logic             IN_VALID;
  logic [WIDTH-1:0] IN_DATA;
  logic             OUT_VALID;
  logic [WIDTH-1:0] OUT_DATA;
  logic             FILLING;
  logic             DEPTH_ERR;
`ifdef REG_PIPE_STATS_EN
  logic [15:0]      OUT_CNT;

  modport master (
    output CE, SCLR, DEPTH, IN_VALID, IN_DATA,
    input  OUT_VALID, OUT_DATA, FILLING, DEPTH_ERR, OUT_CNT
  );
  modport slave (
    input  CE, SCLR, DEPTH, IN_VALID, IN_DATA,
    output OUT_VALID, OUT_DATA, FILLING, DEPTH_ERR, OUT_CNT
  );
`else
  modport master (
    output CE, SCLR, DEPTH, IN_VALID, IN_DATA,
    input  OUT_VALID, OUT_DATA, FILLING, DEPTH_ERR
  );
  modport slave (
    input  CE, SCLR, DEPTH, IN_VALID, IN_DATA,
    output OUT_VALID, OUT_DATA, FILLING, DEPTH_ERR
  );
`endif
endinterface

// File: rtl/reg_pipe.sv
// -----------------------------------------------------------------------------
// reg_pipe
// Run-time selectable latency register pipeline (0..MAX_DEPTH stages) with a
// valid bit per stage. Used to match latency between DSP channels without
// re-synthesis. A depth change invalidates the pipe contents and holds
// OUT_VALID low (FILLING=1) until the first word written after the change
// has reached the selected output stage.
//
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous reset, active-low
//   bus  : reg_pipe_if.slave (CE, SCLR, DEPTH, IN_*, OUT_*, FILLING,
//          DEPTH_ERR, and OUT_CNT when enabled)
//
// Optional feature: define REG_PIPE_STATS_EN to add OUT_CNT, a 16-bit
// saturating count of CE edges on which OUT_VALID was high.
// -----------------------------------------------------------------------------
module reg_pipe #(
  parameter int WIDTH     = 18,
  parameter int MAX_DEPTH = 4
) (
  input  logic     CLK,
  input  logic     RST,
  reg_pipe_if.slave bus
);
  localparam int DW = $clog2(MAX_DEPTH + 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  logic [WIDTH-1:0] s_q [1:MAX_DEPTH];
  logic [WIDTH-1:0] s_d [1:MAX_DEPTH];
  logic [MAX_DEPTH:1] v_q, v_d;
  logic [DW-1:0]    dq_q, dq_d;
  logic [DW-1:0]    fc_q, fc_d;
  state_t           state_q, state_d;
  logic             err_q, err_d;

  logic [DW-1:0]    depth_clamp_s;
  logic             depth_over_s;
  logic [DW-1:0]    fc_next_s;
  logic             fill_done_s;
  logic             out_valid_s;
  logic [WIDTH-1:0] out_data_s;

  // Clamp the requested depth and flag out-of-range requests.
  always_comb begin
    depth_over_s  = (bus.DEPTH > DW'(MAX_DEPTH));
    depth_clamp_s = depth_over_s ? DW'(MAX_DEPTH) : bus.DEPTH;
  end

  // Refill end detection: leave FILL once the first word written on the
  // change edge sits in stage dq. Depths 0 and 1 need one extra edge because
  // the change edge itself is spent entering FILL.
  always_comb begin
    fc_next_s   = fc_q + DW'(1);
    fill_done_s = (dq_q <= DW'(1)) || (fc_next_s >= (dq_q - DW'(1)));
  end

  // Next-state logic: clear > depth change > plain shift.
  always_comb begin
    s_d     = s_q;
    v_d     = v_q;
    dq_d    = dq_q;
    fc_d    = fc_q;
    state_d = state_q;
    err_d   = err_q;
    if (bus.SCLR) begin
      for (int k = 1; k <= MAX_DEPTH; k++) begin
        s_d[k] = '0;
      end
      v_d     = '0;
      dq_d    = depth_clamp_s;
      fc_d    = '0;
      state_d = ST_RUN;
    end else if (bus.CE) begin
      s_d[1] = bus.IN_DATA;
      v_d[1] = bus.IN_VALID;
      for (int k = 2; k <= MAX_DEPTH; k++) begin
        s_d[k] = s_q[k-1];
        v_d[k] = v_q[k-1];
      end
      if (state_q == ST_RUN) begin
        if (depth_over_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (depth_clamp_s != dq_q) begin
          // Old contents belong to the previous latency; only the word
          // entering this edge stays valid.
          for (int k = 2; k <= MAX_DEPTH; k++) begin
            v_d[k] = 1'b0;
          end
          dq_d    = depth_clamp_s;
          fc_d    = '0;
          state_d = ST_FILL;
        end else begin
          state_d = ST_RUN;
        end
      end else begin
        fc_d = fc_next_s;
        if (fill_done_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FILL;
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  // Pipeline, depth, refill and error state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 1; k <= MAX_DEPTH; k++) begin
        s_q[k] <= '0;
      end
      v_q     <= '0;
      dq_q    <= '0;
      fc_q    <= '0;
      state_q <= ST_RUN;
      err_q   <= 1'b0;
    end else begin
      s_q     <= s_d;
      v_q     <= v_d;
      dq_q    <= dq_d;
      fc_q    <= fc_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Output select: depth 0 is a pure combinational bypass.
  always_comb begin
    out_valid_s = bus.IN_VALID;
    out_data_s  = bus.IN_DATA;
    if (dq_q != DW'(0)) begin
      out_data_s  = s_q[dq_q];
      out_valid_s = v_q[dq_q] & (state_q == ST_RUN);
    end else begin
      out_valid_s = bus.IN_VALID;
      out_data_s  = bus.IN_DATA;
    end
  end

  assign bus.OUT_VALID = out_valid_s;
  assign bus.OUT_DATA  = out_data_s;
  assign bus.FILLING   = (state_q == ST_FILL);
  assign bus.DEPTH_ERR = err_q;

`ifdef REG_PIPE_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating count of CE edges carrying a valid output word.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.SCLR) begin
      cnt_d = 16'h0000;
    end else if (bus.CE && out_valid_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'h0001;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Statistics counter register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.OUT_CNT = cnt_q;
`endif

endmodule
